// File: rtl/hanoi_move_sequencer_if.sv
// Move bus between the Tower of Hanoi sequencer and the peg/display consumer.
// One move transfers on each cycle where move_valid and move_ready are both high.
interface hanoi_move_sequencer_if #(
    parameter int NUM_DISKS = 3
);
    logic                 move_valid;
    logic                 move_ready;
    logic [1:0]           move_from;
    logic [1:0]           move_to;
    logic [2:0]           move_disk;
    logic [NUM_DISKS-1:0] move_index;

    modport master (
        output move_valid,
        output move_from,
        output move_to,
        output move_disk,
        output move_index,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  move_from,
        input  move_to,
        input  move_disk,
        input  move_index,
        output move_ready
    );
endinterface

// File: rtl/hanoi_move_sequencer.sv
// Sequences a full Tower of Hanoi solution (peg 0 to peg 2) as back-pressured moves.
// Each move is decoded arithmetically from the 1-based move counter.
module hanoi_move_sequencer #(
    parameter int NUM_DISKS = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    hanoi_move_sequencer_if.master mv
);
    localparam int           W          = NUM_DISKS;
    localparam logic [W-1:0] FIRST_MOVE = W'(1'b1);
    localparam logic [W-1:0] LAST_MOVE  = {W{1'b1}};
    localparam logic [W-1:0] ZERO_MOVE  = {W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       state_r;
    state_t       state_s;
    logic [W-1:0] m_r;
    logic [W-1:0] m_s;
    logic         xfer_s;

    logic         valid_r, busy_r, done_r;
    logic [1:0]   from_r, to_r;
    logic [2:0]   disk_r;
    logic [W-1:0] index_r;

    logic         valid_s, busy_s, done_s;
    logic [1:0]   from_s, to_s;
    logic [2:0]   disk_s;
    logic [W-1:0] index_s;

    // Residue mod 3, folded MSB first so the accumulator never exceeds 5.
    function automatic logic [1:0] mod3(input logic [W:0] v);
        logic [2:0] acc;
        acc = 3'd0;
        for (int i = W; i >= 0; i--) begin
            acc = {acc[1:0], v[i]};
            if (acc >= 3'd3) begin
                acc = acc - 3'd3;
            end else begin
                acc = acc;
            end
        end
        return acc[1:0];
    endfunction

    function automatic logic [2:0] trailing_zeros(input logic [W-1:0] v);
        logic [2:0] cnt;
        logic       found;
        cnt   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (!found && v[i]) begin
                cnt   = 3'(i);
                found = 1'b1;
            end else begin
                cnt   = cnt;
            end
        end
        return cnt;
    endfunction

    // With an even disk count the raw formula ends on peg 1; swapping 1/2 retargets peg 2.
    function automatic logic [1:0] peg_map(input logic [1:0] raw);
        logic [1:0] peg;
        if ((NUM_DISKS % 2) == 0) begin
            case (raw)
                2'd1:    peg = 2'd2;
                2'd2:    peg = 2'd1;
                default: peg = raw;
            endcase
        end else begin
            peg = raw;
        end
        return peg;
    endfunction

    assign xfer_s = valid_r & mv.move_ready;

    // State and move counter register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            m_r     <= ZERO_MOVE;
        end else begin
            state_r <= state_s;
            m_r     <= m_s;
        end
    end

    // Next-state and next-counter logic; abort outranks a simultaneous transfer.
    always_comb begin
        state_s = state_r;
        m_s     = m_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_s = ST_RUN;
                    m_s     = FIRST_MOVE;
                end else begin
                    state_s = ST_IDLE;
                    m_s     = ZERO_MOVE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    m_s     = ZERO_MOVE;
                end else if (xfer_s) begin
                    if (m_r == LAST_MOVE) begin
                        state_s = ST_DONE;
                        m_s     = ZERO_MOVE;
                    end else begin
                        state_s = ST_RUN;
                        m_s     = m_r + FIRST_MOVE;
                    end
                end else begin
                    state_s = ST_RUN;
                    m_s     = m_r;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                m_s     = ZERO_MOVE;
            end
            default: begin
                state_s = ST_IDLE;
                m_s     = ZERO_MOVE;
            end
        endcase
    end

    // Decode the outputs for the upcoming state so they can be registered.
    always_comb begin
        valid_s = (state_s == ST_RUN);
        busy_s  = (state_s == ST_RUN);
        done_s  = (state_s == ST_DONE);
        if (state_s == ST_RUN) begin
            from_s  = peg_map(mod3({1'b0, m_s & (m_s - FIRST_MOVE)}));
            to_s    = peg_map(mod3({1'b0, m_s | (m_s - FIRST_MOVE)} + (W+1)'(1'b1)));
            disk_s  = trailing_zeros(m_s);
            index_s = m_s;
        end else begin
            from_s  = 2'd0;
            to_s    = 2'd0;
            disk_s  = 3'd0;
            index_s = ZERO_MOVE;
        end
    end

    // Output register stage.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            from_r  <= 2'd0;
            to_r    <= 2'd0;
            disk_r  <= 3'd0;
            index_r <= ZERO_MOVE;
        end else begin
            valid_r <= valid_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            from_r  <= from_s;
            to_r    <= to_s;
            disk_r  <= disk_s;
            index_r <= index_s;
        end
    end

    assign mv.move_valid = valid_r;
    assign mv.move_from  = from_r;
    assign mv.move_to    = to_r;
    assign mv.move_disk  = disk_r;
    assign mv.move_index = index_r;
    assign busy          = busy_r;
    assign done          = done_r;
endmodule

// File: doc/hanoi_move_sequencer.md
# hanoi_move_sequencer

Controller that sequences a complete Tower of Hanoi solution for `NUM_DISKS` disks, moving them from peg 0 to peg 2. It emits one move per valid/ready handshake as from-peg, to-peg and disk number, using the 2-bit peg codes of the existing move datapath. It sits between the system start logic and the peg/display consumer. It replaces free-running counter sequencing with a start/abort/done controlled flow that tolerates back-pressure.

## Interface
- `NUM_DISKS`, default 3: number of disks; legal range 1..8. Total moves = 2^NUM_DISKS − 1.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a solution; sampled only in IDLE.
- `abort`  in  1  terminate the current solution; sampled in RUN.
- `move_ready`  in  1  consumer accepts the presented move.
- `move_valid`  out  1  a move is presented.
- `move_from`  out  2  source peg, 0..2.
- `move_to`  out  2  destination peg, 0..2.
- `move_disk`  out  3  disk moved; 0 is the smallest disk.
- `move_index`  out  NUM_DISKS  1-based number of the presented move.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after the last move is accepted.

## Operation
- States: IDLE, RUN, DONE. Internal move counter `m` is NUM_DISKS bits wide.
- IDLE to RUN: on `start`=1 and `abort`=0. Load `m`=1.
- In RUN, the move is derived combinationally from `m`:
  - `move_disk` = number of trailing zeros of `m`.
  - raw_from = (m & (m−1)) mod 3.
  - raw_to = ((m | (m−1)) + 1) mod 3. Compute the sum at NUM_DISKS+1 bits; no truncation before the mod.
  - NUM_DISKS odd: output raw values unchanged.
  - NUM_DISKS even: swap codes 1 and 2 in both from and to, so the tower always ends on peg 2.
- `move_index` = `m`.
- Handshake rules:
  - A move transfers on a cycle with `move_valid` & `move_ready`.
  - `m` increments only on a transfer.
  - While `move_valid`=1 and `move_ready`=0, all move outputs hold stable.
  - `move_valid` never drops in RUN without a transfer, except on abort.
- RUN to DONE: on a transfer with `m` = 2^NUM_DISKS − 1.
- DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally. `start` is ignored in DONE.
- RUN to IDLE on `abort`=1. Abort has priority over a simultaneous transfer: that move is considered issued, but no `done` pulse occurs.
- `start` is ignored in RUN and DONE. In IDLE, `abort`=1 blocks `start` that cycle.
- Moves are never produced with from == to. Pegs code 3 is never produced.

## Timing
- Reset (`reset_n`=0 at an edge):
  - state = IDLE, `m`=0.
  - `move_valid`=0, `busy`=0, `done`=0.
  - `move_from`=0, `move_to`=0, `move_disk`=0, `move_index`=0.
  - Reset mid-RUN discards the solution with no `done` pulse. It overrides `start` and `abort`.
- Outputs in IDLE and DONE: `move_from`, `move_to`, `move_disk`, `move_index` are 0 and `move_valid`=0.
- Start latency: `start` accepted at edge k gives `move_valid`=1 and `busy`=1 with move 1 visible after edge k.
- Throughput: one move per cycle when `move_ready` is held at 1. A full solution takes 2^N − 1 RUN cycles, then 1 DONE cycle.
- `done` rises on the edge after the final transfer. `busy` falls on that same edge.
- The earliest restart is a `start` sampled in the IDLE cycle after DONE.
- All outputs are registered or decoded from registered state only. There is no combinational path from `move_ready`, `start` or `abort` to any output.

## Test plan
- **N=3, `move_ready`=1, single-cycle `start`:** (from,to,disk) sequence must be (0,2,0),(0,1,1),(2,1,0),(0,2,2),(1,0,0),(1,2,1),(0,2,0). Index runs 1..7. `done` pulses on cycle 8, then IDLE.
- **N=2 parameterization:** sequence must be (0,1,0),(0,2,1),(1,2,0), then `done`.
- **N=1:** a single move (0,2,0), then `done`.
- **Back-pressure with N=3:** `move_ready` toggles 1,0,0,1,… Outputs hold stable across every stall. The sequence is identical to the first scenario. `done` occurs only after the 7th transfer.
- **Abort and reset mid-solution:**
  - Abort asserted together with the transfer of move 4: next cycle is IDLE, `move_valid`=0, no `done`.
  - A new `start` then restarts at move 1, (0,2,0).
  - Repeat with `reset_n`=0 during move 5: all outputs are 0 next cycle.
- **Ignored starts:**
  - `start` held high throughout the run: no restart; exactly one `done`.
  - `start`+`abort` in IDLE: remains IDLE.
  - Scoreboard: for N=1..8, model the three peg stacks and check that no move places a larger disk on a smaller one and that the final state is all disks on peg 2.
